exmem_forward_stage: RTL and testbench
======================================

Name: exmem_forward_stage

Overview:
- EX/MEM pipeline register for the LEGv8 pipeline, plus a one-entry MEM/WB destination shadow.
- Owns the forwarding select logic.
- Latches the EX-stage result. The registered result drives EXMEM_InputAddress into the ALU operand-A/B forwarding muxes.
- Generates ForwardA/ForwardB (2-bit) for the instruction currently in EX.

Parameters:
- DATA_W, 64, datapath width.
- REG_W, 5, register-index width.
- ZERO_REG, 31, register index of XZR; never forwarded.

Ports:
- CLOCK  input  1  system clock, rising edge.
- RESET_n  input  1  asynchronous active-low reset.
- stall  input  1  hold EX/MEM contents (memory not ready).
- flush  input  1  replace next EX/MEM contents with a bubble.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_aluResult  input  DATA_W  ALU output / effective address.
- ex_storeData  input  DATA_W  forwarded Rt value for STUR.
- ex_rd  input  REG_W  destination register.
- ex_regWrite  input  1  instruction writes the register file.
- ex_memRead  input  1  load.
- ex_memWrite  input  1  store.
- ex_memToReg  input  1  writeback from memory.
- idex_rn  input  REG_W  operand-A source register of the instruction in EX.
- idex_rm  input  REG_W  operand-B source register of the instruction in EX.
- memwb_commit  input  1  MEM/WB register accepts the EX/MEM contents this cycle.
- EXMEM_InputAddress  output  DATA_W  registered ALU result.
- EXMEM_storeData  output  DATA_W  registered store data.
- EXMEM_rd  output  REG_W  registered destination.
- EXMEM_regWrite, EXMEM_memRead, EXMEM_memWrite, EXMEM_memToReg  output  1 each  registered controls, gated by valid.
- EXMEM_valid  output  1  stage holds a real instruction.
- ForwardA  output  2  operand-A select: 00 reg file, 01 MEM/WB, 10 EX/MEM.
- ForwardB  output  2  same encoding for operand B.
- loadUseHazard  output  1  EX/MEM holds a load whose rd matches idex_rn or idex_rm.

Behaviour:
- Reset (async, RESET_n low):
  - all registered outputs 0, EXMEM_valid 0;
  - shadow wb_rd = 0, wb_regWrite = 0;
  - ForwardA = ForwardB = 00; loadUseHazard = 0.
  - Reset asserted mid-stall discards held contents.
- Capture, rising CLOCK, priority flush > stall > load:
  - flush=1: valid and all four controls cleared next cycle; data/rd fields don't-care (hold). flush wins over a simultaneous stall.
  - stall=1, flush=0: every EX/MEM field holds.
  - otherwise: all fields load from ex_*; valid <= ex_valid.
- Control gating: output controls = stored control AND valid. A bubble can never write the register file or memory.
- Latency: EX inputs appear on EXMEM_* one cycle later.
- MEM/WB shadow:
  - on memwb_commit: wb_rd <= EXMEM_rd; wb_regWrite <= EXMEM_regWrite (already gated).
  - when memwb_commit is 0: wb_regWrite clears next cycle. A stalled MEM slot issues no stale forward.
- ForwardA select (combinational from registered state and idex_*):
  - 10 when EXMEM_regWrite and EXMEM_rd == idex_rn and EXMEM_rd != ZERO_REG;
  - else 01 when wb_regWrite and wb_rd == idex_rn and wb_rd != ZERO_REG;
  - else 00.
  - EX/MEM has priority over MEM/WB (most recent producer).
- ForwardB: identical rule using idex_rm.
- loadUseHazard = EXMEM_memRead and EXMEM_rd != ZERO_REG and (EXMEM_rd == idex_rn or EXMEM_rd == idex_rm).
  - While high, ForwardA/B still follow the rules above.
  - The hazard unit stalls upstream and flushes this stage on the next cycle.
- Encoding 11 is never produced.

Optional Feature:
- Macro EXMEM_FWD_PERF_EN.
- Defined:
  - adds outputs fwdCount (32) and bubbleCount (32), reset 0.
  - fwdCount += 1 on each cycle where ForwardA != 00 or ForwardB != 00, and stall = 0.
  - bubbleCount += 1 each cycle flush = 1.
  - Both counters saturate at 0xFFFFFFFF.
- Not defined: the ports and the logic are both absent.

Test Plan:
- Reset, then ex_valid=1, ex_aluResult=0x10, ex_rd=3, ex_regWrite=1 -> next cycle EXMEM_InputAddress=0x10, EXMEM_rd=3, EXMEM_regWrite=1.
- EX/MEM rd=3 regWrite=1, idex_rn=3, idex_rm=4 -> ForwardA=10, ForwardB=00. Repeat with rd=31 -> ForwardA=00.
- EX/MEM rd=5, MEM/WB shadow rd=5, idex_rm=5 -> ForwardB=10. Then flush a bubble into EX/MEM with commit -> ForwardB=01.
- EX/MEM holds LDUR rd=7, idex_rn=7 -> loadUseHazard=1. Assert flush and stall together -> EXMEM_valid=0, all controls 0.
- stall=1 for 3 cycles with changing ex_* -> EXMEM_* constant. Assert RESET_n low mid-stall -> all outputs 0 immediately, without a clock edge.
- With EXMEM_FWD_PERF_EN: 4 forwarding cycles, 1 stalled forwarding cycle and 2 flushes -> fwdCount=4, bubbleCount=2.

Source files
------------

// File: rtl/exmem_forward_stage_if.sv
// ---------------------------------------------------------------------------
// exmem_forward_stage_if
//
// Purpose: bundles every non-clock/reset signal of the EX/MEM pipeline
// register and forwarding unit. Clock and reset remain plain module ports.
//
// Modports:
//   slave  - the EX/MEM stage itself (exmem_forward_stage)
//   master - the surrounding pipeline that drives EX results and hazard
//            controls and consumes the registered fields and forward selects
//
// Signals (slave view):
//   in : stall, flush, memwb_commit
//   in : ex_valid, ex_aluResult, ex_storeData, ex_rd,
//        ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg
//   in : idex_rn, idex_rm
//   out: EXMEM_InputAddress, EXMEM_storeData, EXMEM_rd, EXMEM_valid,
//        EXMEM_regWrite, EXMEM_memRead, EXMEM_memWrite, EXMEM_memToReg
//   out: ForwardA, ForwardB, loadUseHazard
//   out: fwdCount, bubbleCount (only when EXMEM_FWD_PERF_EN is defined)
// ---------------------------------------------------------------------------
interface exmem_forward_stage_if #(
    parameter int DATA_W = 64,
    parameter int REG_W  = 5
);
    logic              stall;
    logic              flush;
    logic              memwb_commit;

    logic              ex_valid;
    logic [DATA_W-1:0] ex_aluResult;
    logic [DATA_W-1:0] ex_storeData;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_regWrite;
    logic              ex_memRead;
    logic              ex_memWrite;
    logic              ex_memToReg;

    logic [REG_W-1:0]  idex_rn;
    logic [REG_W-1:0]  idex_rm;

    logic [DATA_W-1:0] EXMEM_InputAddress;
    logic [DATA_W-1:0] EXMEM_storeData;
    logic [REG_W-1:0]  EXMEM_rd;
    logic              EXMEM_regWrite;
    logic              EXMEM_memRead;
    logic              EXMEM_memWrite;
    logic              EXMEM_memToReg;
    logic              EXMEM_valid;

    logic [1:0]        ForwardA;
    logic [1:0]        ForwardB;
    logic              loadUseHazard;

`ifdef EXMEM_FWD_PERF_EN
    logic [31:0]       fwdCount;
    logic [31:0]       bubbleCount;
`endif

    modport slave (
        input  stall, flush, memwb_commit,
        input  ex_valid, ex_aluResult, ex_storeData, ex_rd,
        input  ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg,
        input  idex_rn, idex_rm,
        output EXMEM_InputAddress, EXMEM_storeData, EXMEM_rd,
        output EXMEM_regWrite, EXMEM_memRead, EXMEM_memWrite, EXMEM_memToReg,
        output EXMEM_valid,
        output ForwardA, ForwardB, loadUseHazard
`ifdef EXMEM_FWD_PERF_EN
        , output fwdCount, bubbleCount
`endif
    );

    modport master (
        output stall, flush, memwb_commit,
        output ex_valid, ex_aluResult, ex_storeData, ex_rd,
        output ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg,
        output idex_rn, idex_rm,
        input  EXMEM_InputAddress, EXMEM_storeData, EXMEM_rd,
        input  EXMEM_regWrite, EXMEM_memRead, EXMEM_memWrite, EXMEM_memToReg,
        input  EXMEM_valid,
        input  ForwardA, ForwardB, loadUseHazard
`ifdef EXMEM_FWD_PERF_EN
        , input fwdCount, bubbleCount
`endif
    );
endinterface

// File: rtl/exmem_forward_stage.sv
// ---------------------------------------------------------------------------
// exmem_forward_stage
//
// Purpose: LEGv8 EX/MEM pipeline register with a one-entry MEM/WB
// destination shadow and the ALU operand forwarding select logic.
//
// Ports:
//   CLOCK    - system clock, rising edge
//   RESET_n  - asynchronous active-low reset
//   bus      - exmem_forward_stage_if.slave (EX inputs, hazard controls,
//              registered EX/MEM fields, ForwardA/B, loadUseHazard)
//
// Optional feature: define EXMEM_FWD_PERF_EN to add the saturating
// fwdCount / bubbleCount performance counters on the interface.
// ---------------------------------------------------------------------------
module exmem_forward_stage #(
    parameter int DATA_W   = 64,
    parameter int REG_W    = 5,
    parameter int ZERO_REG = 31
) (
    input  logic                  CLOCK,
    input  logic                  RESET_n,
    exmem_forward_stage_if.slave  bus
);
    localparam logic [REG_W-1:0] ZeroIdx = REG_W'(ZERO_REG);

    logic              validQ;
    logic [DATA_W-1:0] aluQ;
    logic [DATA_W-1:0] storeQ;
    logic [REG_W-1:0]  rdQ;
    logic              regWriteQ;
    logic              memReadQ;
    logic              memWriteQ;
    logic              memToRegQ;

    logic [REG_W-1:0]  wbRd;
    logic              wbRegWrite;

    logic              exmemRegWrite;
    logic              exmemMemRead;
    logic [1:0]        fwdA;
    logic [1:0]        fwdB;

    // EX/MEM register: flush beats stall beats load. A flush only kills
    // valid and the controls; data and rd simply hold since a bubble
    // never uses them.
    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            validQ    <= 1'b0;
            aluQ      <= '0;
            storeQ    <= '0;
            rdQ       <= '0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
        end else if (bus.flush) begin
            validQ    <= 1'b0;
            regWriteQ <= 1'b0;
            memReadQ  <= 1'b0;
            memWriteQ <= 1'b0;
            memToRegQ <= 1'b0;
        end else if (!bus.stall) begin
            validQ    <= bus.ex_valid;
            aluQ      <= bus.ex_aluResult;
            storeQ    <= bus.ex_storeData;
            rdQ       <= bus.ex_rd;
            regWriteQ <= bus.ex_regWrite;
            memReadQ  <= bus.ex_memRead;
            memWriteQ <= bus.ex_memWrite;
            memToRegQ <= bus.ex_memToReg;
        end
    end

    // Controls are qualified by valid so a bubble can never write state.
    assign exmemRegWrite = regWriteQ & validQ;
    assign exmemMemRead  = memReadQ  & validQ;

    // MEM/WB shadow: only remembers what is needed for forwarding. When
    // MEM/WB does not accept this cycle, its write-enable drops so a stalled
    // MEM slot cannot keep forwarding a stale producer.
    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            wbRd       <= '0;
            wbRegWrite <= 1'b0;
        end else if (bus.memwb_commit) begin
            wbRd       <= rdQ;
            wbRegWrite <= exmemRegWrite;
        end else begin
            wbRegWrite <= 1'b0;
        end
    end

    // Forward selects: EX/MEM is the most recent producer, so it wins over
    // MEM/WB. XZR is never forwarded. Encoding 2'b11 cannot be produced.
    always_comb begin
        fwdA = 2'b00;
        fwdB = 2'b00;
        if (exmemRegWrite && rdQ != ZeroIdx && rdQ == bus.idex_rn) begin
            fwdA = 2'b10;
        end else if (wbRegWrite && wbRd != ZeroIdx && wbRd == bus.idex_rn) begin
            fwdA = 2'b01;
        end
        if (exmemRegWrite && rdQ != ZeroIdx && rdQ == bus.idex_rm) begin
            fwdB = 2'b10;
        end else if (wbRegWrite && wbRd != ZeroIdx && wbRd == bus.idex_rm) begin
            fwdB = 2'b01;
        end
    end

    assign bus.ForwardA      = fwdA;
    assign bus.ForwardB      = fwdB;
    assign bus.loadUseHazard = exmemMemRead && (rdQ != ZeroIdx) &&
                               ((rdQ == bus.idex_rn) || (rdQ == bus.idex_rm));

    assign bus.EXMEM_InputAddress = aluQ;
    assign bus.EXMEM_storeData    = storeQ;
    assign bus.EXMEM_rd           = rdQ;
    assign bus.EXMEM_valid        = validQ;
    assign bus.EXMEM_regWrite     = exmemRegWrite;
    assign bus.EXMEM_memRead      = exmemMemRead;
    assign bus.EXMEM_memWrite     = memWriteQ & validQ;
    assign bus.EXMEM_memToReg     = memToRegQ & validQ;

`ifdef EXMEM_FWD_PERF_EN
    logic [31:0] fwdCountQ;
    logic [31:0] bubbleCountQ;

    // Saturating counters: forwarding cycles that actually advance (no
    // stall), and every cycle a bubble is injected.
    always_ff @(posedge CLOCK or negedge RESET_n) begin
        if (!RESET_n) begin
            fwdCountQ    <= '0;
            bubbleCountQ <= '0;
        end else begin
            if ((fwdA != 2'b00 || fwdB != 2'b00) && !bus.stall &&
                fwdCountQ != 32'hFFFF_FFFF) begin
                fwdCountQ <= fwdCountQ + 32'd1;
            end
            if (bus.flush && bubbleCountQ != 32'hFFFF_FFFF) begin
                bubbleCountQ <= bubbleCountQ + 32'd1;
            end
        end
    end

    assign bus.fwdCount    = fwdCountQ;
    assign bus.bubbleCount = bubbleCountQ;
`endif
endmodule

// File: tb/tb_exmem_forward_stage.sv
// ---------------------------------------------------------------------------
// tb_exmem_forward_stage
//
// Purpose: self-checking bench for exmem_forward_stage. Table of forwarding
// scenarios, hand-written multi-cycle sequences, then randomized traffic
// against a behavioural model of the pipeline slot.
// Perf-counter checks are compiled in when EXMEM_FWD_PERF_EN is defined.
// ---------------------------------------------------------------------------
module tb_exmem_forward_stage;
    typedef struct packed {
        logic        valid;
        logic [63:0] alu;
        logic [63:0] store;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        m2r;
    } exIn_t;

    typedef struct packed {
        logic [4:0] exRd;
        logic       exRw;
        logic       exMr;
        logic [4:0] wbRd;
        logic       wbRw;
        logic [4:0] rn;
        logic [4:0] rm;
        logic [1:0] expA;
        logic [1:0] expB;
        logic       expHaz;
    } vector_t;

    logic CLOCK = 1'b0;
    logic RESET_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    exmem_forward_stage_if #(.DATA_W(64), .REG_W(5)) bus ();

    exmem_forward_stage #(.DATA_W(64), .REG_W(5), .ZERO_REG(31)) dut (
        .CLOCK   (CLOCK),
        .RESET_n (RESET_n),
        .bus     (bus.slave)
    );

    // 10-unit clock period
    always #5 CLOCK = ~CLOCK;

    // Compare one value and log a failure line on mismatch
    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Drive every input of the stage in one go
    task automatic applyStimulus(input logic st, input logic fl, input logic cm,
                                 input exIn_t e, input logic [4:0] rn, input logic [4:0] rm);
        bus.stall        = st;
        bus.flush        = fl;
        bus.memwb_commit = cm;
        bus.ex_valid     = e.valid;
        bus.ex_aluResult = e.alu;
        bus.ex_storeData = e.store;
        bus.ex_rd        = e.rd;
        bus.ex_regWrite  = e.rw;
        bus.ex_memRead   = e.mr;
        bus.ex_memWrite  = e.mw;
        bus.ex_memToReg  = e.m2r;
        bus.idex_rn      = rn;
        bus.idex_rm      = rm;
    endtask

    function automatic exIn_t mkEx(input logic v, input logic [63:0] alu, input logic [4:0] rd,
                                   input logic rw, input logic mr, input logic mw, input logic m2r);
        exIn_t e;
        e.valid = v;
        e.alu   = alu;
        e.store = alu ^ 64'h5A5A_0000_0000_A5A5;
        e.rd    = rd;
        e.rw    = rw;
        e.mr    = mr;
        e.mw    = mw;
        e.m2r   = m2r;
        return e;
    endfunction

    // Advance one clock, land 1 unit after the rising edge
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 5'd0, 5'd0);
        RESET_n = 1'b0;
        repeat (2) @(posedge CLOCK);
        #1;
        RESET_n = 1'b1;
    endtask

    function automatic logic [4:0] ctrlBits();
        return {bus.EXMEM_valid, bus.EXMEM_regWrite, bus.EXMEM_memRead,
                bus.EXMEM_memWrite, bus.EXMEM_memToReg};
    endfunction

    // Behavioural model: the EX/MEM slot holds the last accepted instruction
    // record (a flush installs a bubble), the shadow remembers the producer
    // that moved on to MEM/WB during a commit cycle.
    exIn_t       slot;
    logic [4:0]  shadowRd;
    logic        shadowLive;
    logic [31:0] mFwd;
    logic [31:0] mBub;

    function automatic logic slotWrites();
        return slot.valid && slot.rw;
    endfunction

    function automatic logic [1:0] modelForward(input logic [4:0] src);
        if (src == 5'd31) return 2'b00;
        if (slotWrites() && slot.rd == src) return 2'b10;
        if (shadowLive && shadowRd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [4:0] pickReg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    vector_t vecs[8];

    initial begin
        exIn_t e;
        logic [1:0] expA;
        logic [1:0] expB;
        logic st, fl, cm;
        logic [4:0] rn, rm;

        //            exRd  rw    mr    wbRd  wbRw  rn    rm    A      B      haz
        vecs[0] = '{5'd3,  1'b1, 1'b0, 5'd9,  1'b1, 5'd3,  5'd4,  2'b10, 2'b00, 1'b0};
        vecs[1] = '{5'd31, 1'b1, 1'b0, 5'd9,  1'b1, 5'd31, 5'd9,  2'b00, 2'b01, 1'b0};
        vecs[2] = '{5'd5,  1'b1, 1'b0, 5'd5,  1'b1, 5'd1,  5'd5,  2'b00, 2'b10, 1'b0};
        vecs[3] = '{5'd5,  1'b0, 1'b0, 5'd5,  1'b1, 5'd5,  5'd5,  2'b01, 2'b01, 1'b0};
        vecs[4] = '{5'd7,  1'b1, 1'b1, 5'd2,  1'b0, 5'd7,  5'd2,  2'b10, 2'b00, 1'b1};
        vecs[5] = '{5'd31, 1'b1, 1'b1, 5'd31, 1'b1, 5'd31, 5'd31, 2'b00, 2'b00, 1'b0};
        vecs[6] = '{5'd12, 1'b0, 1'b1, 5'd0,  1'b1, 5'd0,  5'd12, 2'b01, 2'b00, 1'b1};
        vecs[7] = '{5'd0,  1'b1, 1'b0, 5'd0,  1'b1, 5'd0,  5'd0,  2'b10, 2'b10, 1'b0};

        doReset();

        // Reset state
        checkOutput("rst_addr", bus.EXMEM_InputAddress, 64'd0);
        checkOutput("rst_store", bus.EXMEM_storeData, 64'd0);
        checkOutput("rst_rd", bus.EXMEM_rd, 64'd0);
        checkOutput("rst_ctrl", ctrlBits(), 64'd0);
        checkOutput("rst_fwdA", bus.ForwardA, 64'd0);
        checkOutput("rst_fwdB", bus.ForwardB, 64'd0);
        checkOutput("rst_haz", bus.loadUseHazard, 64'd0);
`ifdef EXMEM_FWD_PERF_EN
        checkOutput("rst_fwdCount", bus.fwdCount, 64'd0);
        checkOutput("rst_bubbleCount", bus.bubbleCount, 64'd0);
`endif

        // One-cycle latency
        applyStimulus(1'b0, 1'b0, 1'b0, mkEx(1'b1, 64'h10, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 5'd0, 5'd0);
        #1;
        checkOutput("lat_before", bus.EXMEM_InputAddress, 64'd0);
        tick();
        checkOutput("lat_addr", bus.EXMEM_InputAddress, 64'h10);
        checkOutput("lat_rd", bus.EXMEM_rd, 64'd3);
        checkOutput("lat_regWrite", bus.EXMEM_regWrite, 64'd1);
        checkOutput("lat_valid", bus.EXMEM_valid, 64'd1);

        // Forwarding table: first cycle places the MEM/WB producer in EX/MEM,
        // second cycle commits it to the shadow while loading the EX/MEM one
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0,
                          mkEx(1'b1, 64'(i), vecs[i].wbRd, vecs[i].wbRw, 1'b0, 1'b0, 1'b0), 5'd30, 5'd30);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b1,
                          mkEx(1'b1, 64'(i + 100), vecs[i].exRd, vecs[i].exRw, vecs[i].exMr, 1'b0, vecs[i].exMr),
                          5'd30, 5'd30);
            tick();
            applyStimulus(1'b0, 1'b0, 1'b0, '0, vecs[i].rn, vecs[i].rm);
            #1;
            checkOutput($sformatf("vec%0d_fwdA", i), bus.ForwardA, 64'(vecs[i].expA));
            checkOutput($sformatf("vec%0d_fwdB", i), bus.ForwardB, 64'(vecs[i].expB));
            checkOutput($sformatf("vec%0d_haz", i), bus.loadUseHazard, 64'(vecs[i].expHaz));
        end

        // EX/MEM and shadow both rd=5: EX/MEM wins, then a flushed bubble
        // with commit exposes the shadow copy, which expires without commit
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, mkEx(1'b1, 64'h50, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 5'd30, 5'd30);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, mkEx(1'b1, 64'h51, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0), 5'd30, 5'd30);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 5'd30, 5'd5);
        #1;
        checkOutput("prio_fwdB", bus.ForwardB, 64'b10);
        applyStimulus(1'b0, 1'b1, 1'b1, mkEx(1'b1, 64'h52, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0), 5'd30, 5'd5);
        tick();
        checkOutput("bubble_valid", bus.EXMEM_valid, 64'd0);
        checkOutput("bubble_fwdB", bus.ForwardB, 64'b01);
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 5'd30, 5'd5);
        tick();
        checkOutput("shadow_expire_fwdB", bus.ForwardB, 64'b00);

        // Load-use hazard, then flush together with stall
        applyStimulus(1'b0, 1'b0, 1'b0, mkEx(1'b1, 64'h70, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1), 5'd30, 5'd30);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 5'd7, 5'd8);
        #1;
        checkOutput("ldu_haz", bus.loadUseHazard, 64'd1);
        checkOutput("ldu_fwdA", bus.ForwardA, 64'b10);
        applyStimulus(1'b1, 1'b1, 1'b0, mkEx(1'b1, 64'h71, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1), 5'd7, 5'd8);
        tick();
        checkOutput("flushstall_ctrl", ctrlBits(), 64'd0);
        checkOutput("flushstall_haz", bus.loadUseHazard, 64'd0);

        // Three stalled cycles with changing EX inputs must hold everything
        applyStimulus(1'b0, 1'b0, 1'b0, mkEx(1'b1, 64'hABC, 5'd9, 1'b1, 1'b0, 1'b1, 1'b0), 5'd30, 5'd30);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0,
                          mkEx(1'b1, 64'($urandom), 5'(i + 10), 1'b0, 1'b1, 1'b0, 1'b1), 5'd9, 5'd30);
            tick();
            checkOutput($sformatf("stall%0d_addr", i), bus.EXMEM_InputAddress, 64'hABC);
            checkOutput($sformatf("stall%0d_rd", i), bus.EXMEM_rd, 64'd9);
            checkOutput($sformatf("stall%0d_ctrl", i), ctrlBits(), 64'b11010);
        end
        // Asynchronous reset in the middle of a stall, away from any edge
        #2;
        RESET_n = 1'b0;
        #1;
        checkOutput("arst_addr", bus.EXMEM_InputAddress, 64'd0);
        checkOutput("arst_rd", bus.EXMEM_rd, 64'd0);
        checkOutput("arst_ctrl", ctrlBits(), 64'd0);
        checkOutput("arst_fwdA", bus.ForwardA, 64'd0);
        checkOutput("arst_store", bus.EXMEM_storeData, 64'd0);
        @(negedge CLOCK);
        RESET_n = 1'b1;

`ifdef EXMEM_FWD_PERF_EN
        // Counters: 4 advancing forward cycles, 1 stalled one, 2 flushes
        doReset();
        applyStimulus(1'b0, 1'b0, 1'b0, mkEx(1'b1, 64'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 5'd3, 5'd30);
        tick();
        repeat (4) tick();
        applyStimulus(1'b1, 1'b0, 1'b0, mkEx(1'b1, 64'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0), 5'd3, 5'd30);
        tick();
        applyStimulus(1'b0, 1'b1, 1'b0, '0, 5'd20, 5'd21);
        repeat (2) tick();
        applyStimulus(1'b0, 1'b0, 1'b0, '0, 5'd20, 5'd21);
        #1;
        checkOutput("perf_fwdCount", bus.fwdCount, 64'd4);
        checkOutput("perf_bubbleCount", bus.bubbleCount, 64'd2);
`endif

        // Randomized traffic against the behavioural model
        doReset();
        slot       = '0;
        shadowRd   = 5'd0;
        shadowLive = 1'b0;
        mFwd       = 32'd0;
        mBub       = 32'd0;
        for (int n = 0; n < 300; n++) begin
            st = ($urandom_range(0, 9) < 2);
            fl = ($urandom_range(0, 9) < 1);
            cm = ($urandom_range(0, 1) == 1);
            e.valid = ($urandom_range(0, 3) != 0);
            e.alu   = {32'($urandom), 32'($urandom)};
            e.store = {32'($urandom), 32'($urandom)};
            e.rd    = pickReg();
            e.rw    = 1'($urandom);
            e.mr    = 1'($urandom);
            e.mw    = 1'($urandom);
            e.m2r   = 1'($urandom);
            rn = pickReg();
            rm = pickReg();
            applyStimulus(st, fl, cm, e, rn, rm);
            #1;
            expA = modelForward(rn);
            expB = modelForward(rm);
            checkOutput("rnd_addr", bus.EXMEM_InputAddress, slot.alu);
            checkOutput("rnd_store", bus.EXMEM_storeData, slot.store);
            checkOutput("rnd_rd", bus.EXMEM_rd, 64'(slot.rd));
            checkOutput("rnd_ctrl", ctrlBits(),
                        64'({slot.valid, slot.valid & slot.rw, slot.valid & slot.mr,
                             slot.valid & slot.mw, slot.valid & slot.m2r}));
            checkOutput("rnd_fwdA", bus.ForwardA, 64'(expA));
            checkOutput("rnd_fwdB", bus.ForwardB, 64'(expB));
            checkOutput("rnd_haz", bus.loadUseHazard,
                        64'(slot.valid && slot.mr && slot.rd != 5'd31 &&
                            (slot.rd == rn || slot.rd == rm)));
`ifdef EXMEM_FWD_PERF_EN
            checkOutput("rnd_fwdCount", bus.fwdCount, 64'(mFwd));
            checkOutput("rnd_bubbleCount", bus.bubbleCount, 64'(mBub));
            if ((expA != 2'b00 || expB != 2'b00) && !st && mFwd != 32'hFFFF_FFFF) mFwd = mFwd + 1;
            if (fl && mBub != 32'hFFFF_FFFF) mBub = mBub + 1;
`endif
            @(posedge CLOCK);
            // Producer leaving EX/MEM this edge becomes the shadow
            shadowLive = cm && slotWrites();
            if (cm) shadowRd = slot.rd;
            if (fl) begin
                slot.valid = 1'b0;
                slot.rw    = 1'b0;
                slot.mr    = 1'b0;
                slot.mw    = 1'b0;
                slot.m2r   = 1'b0;
            end else if (!st) begin
                slot = e;
            end
            #1;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
